// File: rtl/tt_move_ctrl_pkg.sv
// Shared types and helpers for the tic-tac-toe move controller.
// State encodings, game-state codes, button bit positions and cell-index helpers.
package tt_move_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PLACE  = 2'b01,
        ST_WAIT   = 2'b10,
        ST_LOCKED = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        GS_PLAY = 2'b00,
        GS_XWIN = 2'b01,
        GS_OWIN = 2'b10,
        GS_DRAW = 2'b11
    } game_state_t;

    // Bit positions inside the packed button / rising-edge vectors
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_PLACE = 4;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } skip_t;

    // Board cell index 3*row + col
    function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} << 1) + {2'b00, row} + {2'b00, col};
    endfunction

    // Cursor step with wrap 2 -> 0
    function automatic logic [1:0] wrap_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Cursor step with wrap 0 -> 2
    function automatic logic [1:0] wrap_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd2 : v - 2'd1;
    endfunction

    function automatic logic [1:0] idx_row(input logic [3:0] idx);
        if (idx >= 4'd6)
            return 2'd2;
        else if (idx >= 4'd3)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic [1:0] idx_col(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd4, 4'd7: return 2'd1;
            4'd2, 4'd5, 4'd8: return 2'd2;
            default:          return 2'd0;
        endcase
    endfunction

    // First empty cell after idx in ascending order, wrapping 8 -> 0
    function automatic skip_t next_empty(input logic [8:0] valid, input logic [3:0] idx);
        skip_t       r;
        int unsigned c;
        r.found = 1'b0;
        r.idx   = idx;
        for (int unsigned k = 1; k < 9; k++) begin
            c = (32'(idx) + k) % 9;
            if (!r.found && !valid[4'(c)]) begin
                r.found = 1'b1;
                r.idx   = 4'(c);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tt_move_ctrl_if.sv
// Link between the move controller and the board controller.
// master = move controller (drives cursor and set strobe), slave = board.
interface tt_move_ctrl_if;
    logic [1:0] row;
    logic [1:0] col;
    logic       set;
    logic [8:0] valid;
    logic [1:0] game_state;

    modport master (
        output row, col, set,
        input  valid, game_state
    );

    modport slave (
        input  row, col, set,
        output valid, game_state
    );
endinterface

// File: rtl/tt_btn_edge.sv
// 5-bit rising-edge detector for pre-synchronised button levels.
// History register clears to 0, so a button held through reset fires once afterwards.
module tt_btn_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn,
    output logic [4:0] rise
);
    logic [4:0] btn_q;

    // Previous-cycle button levels, updated every cycle regardless of controller state
    always_ff @(posedge clk) begin
        if (reset)
            btn_q <= '0;
        else
            btn_q <= btn;
    end

    assign rise = btn & ~btn_q;
endmodule

// File: rtl/tt_move_ctrl.sv
// Player-input front end for the tic-tac-toe board controller.
// Turns button edges into cursor moves and a one-cycle set strobe, rejects moves on
// occupied cells, waits for the board to register each move, and locks on game end.
// Optional feature macro: AUTO_SKIP_EN (cursor jumps to next empty cell after a move).
module tt_move_ctrl
    import tt_move_ctrl_pkg::*;
#(
    parameter int unsigned UPD_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_place,
    tt_move_ctrl_if.master        board,
    output logic                  illegal,
    output logic                  err_timeout,
    output logic                  busy,
    output logic                  locked,
    output logic [3:0]            move_count
);
    localparam logic [3:0] TIMER_LAST = 4'(UPD_TIMEOUT - 1);

    state_t     state;
    logic [1:0] row_q;
    logic [1:0] col_q;
    logic       set_q;
    logic [3:0] timer;
    logic [4:0] rise;
    logic [3:0] cur_idx;
    logic       cur_occ;

    tt_btn_edge u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .btn   ({btn_place, btn_right, btn_left, btn_down, btn_up}),
        .rise  (rise)
    );

    assign cur_idx   = cell_idx(row_q, col_q);
    assign cur_occ   = board.valid[cur_idx];
    assign board.row = row_q;
    assign board.col = col_q;
    assign board.set = set_q;

`ifdef AUTO_SKIP_EN
    skip_t skip;
    // board.valid already includes the just-registered cell when this is used
    assign skip = next_empty(board.valid, cur_idx);
`endif

    // Controller FSM with registered cursor, strobes and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            row_q       <= 2'd1;
            col_q       <= 2'd1;
            set_q       <= 1'b0;
            illegal     <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
            locked      <= 1'b0;
            move_count  <= '0;
            timer       <= '0;
        end else begin
            set_q       <= 1'b0;
            illegal     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (board.game_state != GS_PLAY) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                    end else if (rise[BTN_PLACE]) begin
                        if (cur_occ) begin
                            illegal <= 1'b1;
                        end else begin
                            state <= ST_PLACE;
                            set_q <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end else if (rise[BTN_UP]) begin
                        row_q <= wrap_dec(row_q);
                    end else if (rise[BTN_DOWN]) begin
                        row_q <= wrap_inc(row_q);
                    end else if (rise[BTN_LEFT]) begin
                        col_q <= wrap_dec(col_q);
                    end else if (rise[BTN_RIGHT]) begin
                        col_q <= wrap_inc(col_q);
                    end
                end
                ST_PLACE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cur_occ) begin
                        if (move_count != 4'd9)
                            move_count <= move_count + 4'd1;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
`ifdef AUTO_SKIP_EN
                        if (skip.found) begin
                            row_q <= idx_row(skip.idx);
                            col_q <= idx_col(skip.idx);
                        end
`endif
                    end else if (timer == TIMER_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        timer <= timer + 4'd1;
                    end
                end
                ST_LOCKED: begin
                    state <= ST_LOCKED;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tt_move_ctrl.sv
// Directed self-checking bench for tt_move_ctrl: table-driven cursor/illegal vectors
// plus hand-written sequences for place/wait, timeout, lockout, reset and saturation.
module tb_tt_move_ctrl;
    logic       clk;
    logic       reset;
    logic [4:0] btns;   // {place, right, left, down, up}
    logic       illegal;
    logic       err_timeout;
    logic       busy;
    logic       locked;
    logic [3:0] move_count;

    int checks;
    int errors;

    localparam logic [4:0] B_UP    = 5'b00001;
    localparam logic [4:0] B_DOWN  = 5'b00010;
    localparam logic [4:0] B_LEFT  = 5'b00100;
    localparam logic [4:0] B_RIGHT = 5'b01000;
    localparam logic [4:0] B_PLACE = 5'b10000;

    typedef struct {
        logic [4:0] btn;
        logic [8:0] valid;
        logic [1:0] row;
        logic [1:0] col;
        logic       illegal;
    } vec_t;

    vec_t vecs[13];

    tt_move_ctrl_if bus ();

    tt_move_ctrl #(.UPD_TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up      (btns[0]),
        .btn_down    (btns[1]),
        .btn_left    (btns[2]),
        .btn_right   (btns[3]),
        .btn_place   (btns[4]),
        .board       (bus),
        .illegal     (illegal),
        .err_timeout (err_timeout),
        .busy        (busy),
        .locked      (locked),
        .move_count  (move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        btns           = '0;
        bus.valid      = '0;
        bus.game_state = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cycles;
        checks = 0;
        errors = 0;

        // cursor walk from centre, priority combos, illegal places
        vecs[0]  = '{B_RIGHT,                  9'h000, 2'd1, 2'd2, 1'b0};
        vecs[1]  = '{B_RIGHT,                  9'h000, 2'd1, 2'd0, 1'b0};
        vecs[2]  = '{B_DOWN,                   9'h000, 2'd2, 2'd0, 1'b0};
        vecs[3]  = '{B_UP,                     9'h000, 2'd1, 2'd0, 1'b0};
        vecs[4]  = '{B_UP,                     9'h000, 2'd0, 2'd0, 1'b0};
        vecs[5]  = '{B_UP,                     9'h000, 2'd2, 2'd0, 1'b0};
        vecs[6]  = '{B_LEFT,                   9'h000, 2'd2, 2'd2, 1'b0};
        vecs[7]  = '{B_UP | B_DOWN,            9'h000, 2'd1, 2'd2, 1'b0};
        vecs[8]  = '{B_LEFT | B_RIGHT,         9'h000, 2'd1, 2'd1, 1'b0};
        vecs[9]  = '{B_DOWN | B_LEFT | B_RIGHT, 9'h000, 2'd2, 2'd1, 1'b0};
        vecs[10] = '{B_PLACE,                  9'h080, 2'd2, 2'd1, 1'b1};
        vecs[11] = '{B_PLACE | B_UP,           9'h080, 2'd2, 2'd1, 1'b1};
        vecs[12] = '{B_UP | B_RIGHT,           9'h000, 2'd1, 2'd1, 1'b0};

        reset          = 1'b1;
        btns           = '0;
        bus.valid      = '0;
        bus.game_state = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_row", bus.row, 1);
        chk("rst_col", bus.col, 1);
        chk("rst_set", bus.set, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_count", move_count, 0);

        for (int i = 0; i < 13; i++) begin
            btns      = vecs[i].btn;
            bus.valid = vecs[i].valid;
            @(negedge clk);
            btns = '0;
            chk($sformatf("vec%0d_row", i), bus.row, vecs[i].row);
            chk($sformatf("vec%0d_col", i), bus.col, vecs[i].col);
            chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].illegal);
            chk($sformatf("vec%0d_set", i), bus.set, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_illegal_clr", i), illegal, 0);
        end
        bus.valid = '0;

        // held button moves the cursor only once
        btns = B_RIGHT;
        @(negedge clk);
        chk("hold_first", bus.col, 2);
        @(negedge clk);
        @(negedge clk);
        chk("hold_no_repeat", bus.col, 2);
        btns = '0;
        @(negedge clk);

        // successful place at centre
        do_reset();
        btns = B_PLACE;
        @(negedge clk);
        btns = '0;
        chk("place_set", bus.set, 1);
        chk("place_busy", busy, 1);
        bus.valid = 9'h010;
        @(negedge clk);
        chk("wait_set_low", bus.set, 0);
        chk("wait_busy", busy, 1);
        chk("wait_row", bus.row, 1);
        chk("wait_col", bus.col, 1);
        @(negedge clk);
        chk("place_count", move_count, 1);
        chk("place_busy_low", busy, 0);
`ifdef AUTO_SKIP_EN
        chk("place_skip_col", bus.col, 2);
        btns = B_LEFT;
        @(negedge clk);
        btns = '0;
        @(negedge clk);
`else
        chk("place_stay_col", bus.col, 1);
`endif

        // place on occupied centre
        btns = B_PLACE;
        @(negedge clk);
        btns = '0;
        chk("occ_illegal", illegal, 1);
        chk("occ_set", bus.set, 0);
        @(negedge clk);
        chk("occ_illegal_clr", illegal, 0);
        chk("occ_set2", bus.set, 0);
        chk("occ_count", move_count, 1);

        // board never registers the move
        do_reset();
        btns = B_PLACE;
        @(negedge clk);
        btns = '0;
        chk("to_set", bus.set, 1);
        wait_cycles = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (err_timeout) begin
                wait_cycles = i;
                break;
            end
        end
        chk("to_latency", wait_cycles, 5);
        chk("to_busy", busy, 0);
        chk("to_count", move_count, 0);
        @(negedge clk);
        chk("to_err_clr", err_timeout, 0);

        // reset during PLACE drops set next cycle
        btns = B_PLACE;
        @(negedge clk);
        btns  = '0;
        chk("rp_set", bus.set, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rp_set_low", bus.set, 0);
        chk("rp_busy", busy, 0);

        // reset during WAIT while board registers: no increment
        btns = B_PLACE;
        @(negedge clk);
        btns = '0;
        @(negedge clk);
        chk("rw_busy", busy, 1);
        bus.valid = '1;
        reset     = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.valid = '0;
        chk("rw_count", move_count, 0);
        chk("rw_busy_low", busy, 0);

        // win locks out all input
        do_reset();
        bus.game_state = 2'b01;
        @(negedge clk);
        chk("lk_locked", locked, 1);
        chk("lk_busy", busy, 0);
        btns = B_PLACE;
        @(negedge clk);
        btns = '0;
        chk("lk_no_set", bus.set, 0);
        btns = B_RIGHT;
        @(negedge clk);
        btns = B_DOWN;
        @(negedge clk);
        btns = '0;
        chk("lk_row", bus.row, 1);
        chk("lk_col", bus.col, 1);
        bus.game_state = 2'b00;
        @(negedge clk);
        chk("lk_stays", locked, 1);
        do_reset();
        chk("lk_rst_locked", locked, 0);
        chk("lk_rst_row", bus.row, 1);
        chk("lk_rst_col", bus.col, 1);

        // draw with a simultaneous place edge: lock wins
        bus.game_state = 2'b11;
        btns           = B_PLACE;
        @(negedge clk);
        btns = '0;
        chk("dr_locked", locked, 1);
        chk("dr_set", bus.set, 0);
        do_reset();

        // move_count saturates at 9
        for (int i = 1; i <= 10; i++) begin
            btns = B_PLACE;
            @(negedge clk);
            btns      = '0;
            bus.valid = '1;
            @(negedge clk);
            @(negedge clk);
            bus.valid = '0;
            chk($sformatf("sat%0d_count", i), move_count, (i > 9) ? 9 : i);
        end

        // place at idx 5, then place and up in the same cycle
        do_reset();
        btns = B_RIGHT;
        @(negedge clk);
        btns      = '0;
        bus.valid = 9'h01F;
        @(negedge clk);
        btns = B_PLACE;
        @(negedge clk);
        btns = '0;
        chk("sk_set", bus.set, 1);
        bus.valid = 9'h03F;
        @(negedge clk);
        @(negedge clk);
        chk("sk_count", move_count, 1);
`ifdef AUTO_SKIP_EN
        chk("sk_row", bus.row, 2);
        chk("sk_col", bus.col, 0);
        btns = B_PLACE | B_UP;
        @(negedge clk);
        btns = '0;
        chk("pu_set", bus.set, 1);
        chk("pu_row", bus.row, 2);
        chk("pu_col", bus.col, 0);
        bus.valid = 9'h07F;
        @(negedge clk);
        @(negedge clk);
        chk("pu_count", move_count, 2);
        chk("pu_skip_row", bus.row, 2);
        chk("pu_skip_col", bus.col, 1);
`else
        chk("sk_row", bus.row, 1);
        chk("sk_col", bus.col, 2);
        btns = B_PLACE | B_UP;
        @(negedge clk);
        btns = '0;
        chk("pu_illegal", illegal, 1);
        chk("pu_set", bus.set, 0);
        chk("pu_row", bus.row, 1);
        chk("pu_col", bus.col, 2);
        @(negedge clk);
        @(negedge clk);
        chk("pu_count", move_count, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
